// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, widths and helpers for the fetch stage
package fetch_pkg;
  localparam int ILEN = 32;
  localparam int XLEN_DEF = 32;
  // Widest PC a buffer entry can hold; narrower PCs are zero-extended.
  localparam int PC_MAX = 64;
  typedef struct packed {
    logic [PC_MAX-1:0] pc;
    logic [ILEN-1:0]   instr;
    logic              filled;
  } fetch_entry_t;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/adder_rv.sv
// adder_rv: W-bit adder with carry out
//   a, b : operands
//   sum  : a + b modulo 2^W
//   cout : carry out of bit W-1
module adder_rv #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/en_ff.sv
// en_ff: enabled register with asynchronous active-high reset to RST_VAL
//   clk, rst : clock and reset
//   en, d    : load enable and data
//   q        : registered value
module en_ff #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular in-order prefetch store of {pc, instr, filled} entries
//   alloc/alloc_pc : reserve the next entry for an issued request
//   fill/fill_data : complete the oldest unfilled entry with its instruction
//   pop            : free the head entry
//   flush          : drop all entries and reset pointers
//   head_*         : head entry, valid only once allocated and filled
//   occ, unfilled  : allocated entries and allocated-but-unfilled entries
module fetch_buffer import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_instr,
  output logic [PW:0]     occ,
  output logic [PW:0]     unfilled
);
  localparam int OW = PW + 1;
  fetch_entry_t mem [DEPTH];
  fetch_entry_t head;
  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic unused_pc_hi;
  assign head = mem[head_ptr];
  assign head_valid = occ != '0 && head.filled;
  // Empty outputs read as zero so decode never sees stale contents.
  assign head_pc = head_valid ? head.pc[XLEN-1:0] : '0;
  assign head_instr = head_valid ? head.instr : '0;
  assign unused_pc_hi = ^head.pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr <= '0;
      head_ptr <= '0;
      occ <= '0;
      unfilled <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
      alloc_ptr <= '0;
      fill_ptr <= '0;
      head_ptr <= '0;
      occ <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        mem[alloc_ptr] <= '{pc: PC_MAX'(alloc_pc), instr: '0, filled: 1'b0};
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        mem[fill_ptr].instr <= fill_data;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      occ <= occ + OW'(alloc) - OW'(pop);
      unfilled <= unfilled + OW'(alloc) - OW'(fill);
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch stage with prefetch buffer and redirect flush
//   fetch_clk, fetch_rst        : clock, asynchronous active-high reset
//   imem_req_* / imem_rsp_*     : in-order memory request/response channel
//   redirect_valid, redirect_pc : flush and restart fetch at redirect_pc
//   out_valid/ready, out_pc/instr : (pc, instr) stream to decode
//   pc_error                    : sticky PC overflow / misaligned redirect flag
module fetch_prefetch_unit import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            fetch_clk,
  input  logic            fetch_rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            pc_error
);
  localparam int PW = ptr_w(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = PW + 2;
  logic [XLEN-1:0] fpc, fpc_inc;
  logic carry, err, req_fire, fill, pop;
  logic [PW:0] occ, unfilled, drop_cnt;
  adder_rv #(.W(XLEN)) u_inc (
    .a(fpc), .b(XLEN'(4)), .sum(fpc_inc), .cout(carry)
  );
  en_ff #(.W(XLEN), .RST_VAL(RESET_VEC)) u_fpc (
    .clk(fetch_clk), .rst(fetch_rst), .en(req_fire || redirect_valid),
    .d(redirect_valid ? redirect_pc : fpc_inc), .q(fpc)
  );
  // Responses still owed for flushed requests hold slots until they return.
  assign imem_req_valid = !fetch_rst && !err && !redirect_valid &&
                          (CW'(occ) + CW'(drop_cnt) < CW'(DEPTH));
  assign imem_req_addr = fpc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign fill = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign pop = out_valid && out_ready;
  assign pc_error = err;
  always_ff @(posedge fetch_clk or posedge fetch_rst)
    if (fetch_rst) begin
      drop_cnt <= '0;
      err <= 1'b0;
    end else if (redirect_valid) begin
      // A response arriving now is either already owed to drop_cnt or
      // belongs to one of the entries being flushed; either way it is consumed.
      drop_cnt <= drop_cnt + unfilled - OW'(imem_rsp_valid);
      err <= redirect_pc[1:0] != 2'b00;
    end else begin
      drop_cnt <= drop_cnt - OW'(imem_rsp_valid && drop_cnt != '0);
      if (req_fire && carry) err <= 1'b1;
    end
  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) u_buf (
    .clk(fetch_clk), .rst(fetch_rst), .flush(redirect_valid),
    .alloc(req_fire), .alloc_pc(fpc),
    .fill(fill), .fill_data(imem_rsp_data), .pop(pop),
    .head_valid(out_valid), .head_pc(out_pc), .head_instr(out_instr),
    .occ(occ), .unfilled(unfilled)
  );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed scoreboard bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, req_valid, req_ready = 1'b1, rsp_valid = 1'b0;
  logic redirect = 1'b0, out_valid, out_ready = 1'b0, pc_error;
  logic [31:0] req_addr, rsp_data = '0, redirect_pc = '0, out_pc, out_instr;
  logic rst8 = 1'b1, req_valid8, req_ready8 = 1'b1, rsp_valid8 = 1'b0;
  logic redirect8 = 1'b0, out_valid8, out_ready8 = 1'b1, pc_error8;
  logic [7:0] req_addr8, redirect_pc8 = '0, out_pc8;
  logic [31:0] rsp_data8 = '0, out_instr8;
  int pass_cnt = 0, total = 0, acc_cnt = 0, deliv = 0, acc8 = 0, deliv8 = 0;
  bit stall = 1'b0;
  logic [31:0] mq[$], exp_q[$];
  logic [7:0] exp8[$];

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'h0)) dut (
    .fetch_clk(clk), .fetch_rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .pc_error(pc_error)
  );
  fetch_prefetch_unit #(.XLEN(8), .DEPTH(4), .RESET_VEC(8'h0)) dut8 (
    .fetch_clk(clk), .fetch_rst(rst8),
    .imem_req_valid(req_valid8), .imem_req_ready(req_ready8), .imem_req_addr(req_addr8),
    .imem_rsp_valid(rsp_valid8), .imem_rsp_data(rsp_data8),
    .redirect_valid(redirect8), .redirect_pc(redirect_pc8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_pc(out_pc8), .out_instr(out_instr8),
    .pc_error(pc_error8)
  );

  function automatic logic [31:0] f(input logic [31:0] p);
    return p ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory with variable latency for the 32-bit unit: in-order queue, stallable.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      rsp_valid <= 1'b0;
    end else begin
      if (!stall && mq.size() > 0) begin
        rsp_valid <= 1'b1;
        rsp_data <= f(mq.pop_front());
      end else rsp_valid <= 1'b0;
      if (req_valid && req_ready) begin
        mq.push_back(req_addr);
        acc_cnt++;
      end
    end
  end

  // Fixed one-cycle memory for the 8-bit unit.
  always @(posedge clk) begin
    rsp_valid8 <= !rst8 && req_valid8 && req_ready8;
    rsp_data8 <= f({24'b0, req_addr8});
    if (!rst8 && req_valid8 && req_ready8) acc8++;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_pc, 32'hFFFF_FFFF);
      else begin
        automatic logic [31:0] p = exp_q.pop_front();
        chk("out_pc", out_pc, p);
        chk("out_instr", out_instr, f(p));
      end
      deliv++;
    end
    if (!rst8 && out_valid8 && out_ready8) begin
      if (exp8.size() == 0) chk("unexpected_out8", {24'b0, out_pc8}, 32'hFFFF_FFFF);
      else begin
        automatic logic [7:0] p = exp8.pop_front();
        chk("out_pc8", {24'b0, out_pc8}, {24'b0, p});
        chk("out_instr8", out_instr8, f({24'b0, p}));
      end
      deliv8++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d", pass_cnt, total);
    $fatal(1);
  end

  initial begin
    int n, a0, d0;
    tick(2);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, req_valid}, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_pc_error", {31'b0, pc_error}, 0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", {31'b0, req_valid}, 1);
    chk("first_req_addr", req_addr, 0);
    chk("first_out_valid", {31'b0, out_valid}, 0);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    // Decode stalled: buffer must fill with exactly DEPTH requests.
    n = 0;
    while (req_valid && n < 20) begin @(negedge clk); n++; end
    chk("full_timeout", 32'(n < 20), 1);
    chk("full_acc", acc_cnt, 4);
    repeat (3) @(negedge clk);
    chk("full_hold_acc", acc_cnt, 4);
    chk("full_req_valid", {31'b0, req_valid}, 0);
    chk("full_out_valid", {31'b0, out_valid}, 1);
    chk("full_out_pc", out_pc, 0);
    chk("full_out_instr", out_instr, f(0));
    chk("full_deliv", deliv, 0);
    tick(1);
    out_ready = 1'b1;
    tick(10);
    d0 = deliv;
    tick(8);
    chk("throughput", deliv - d0, 8);
    // Build up exactly three outstanding requests, then redirect.
    stall = 1'b1;
    n = 0;
    while (mq.size() != 3 && n < 20) begin @(negedge clk); n++; end
    req_ready = 1'b0;
    chk("outst_timeout", 32'(n < 20), 1);
    repeat (4) @(negedge clk);
    chk("outst_out_valid", {31'b0, out_valid}, 0);
    chk("outst_count", acc_cnt - deliv, 3);
    tick(1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    req_ready = 1'b1;
    a0 = acc_cnt;
    @(negedge clk);
    chk("redir_req_valid", {31'b0, req_valid}, 0);
    tick(1);
    redirect = 1'b0;
    stall = 1'b0;
    chk("redir_no_accept", acc_cnt, a0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    d0 = deliv;
    tick(20);
    chk("redir_stream", 32'(deliv - d0 >= 8), 1);
    // Misaligned redirect sets the sticky error and stops fetching.
    redirect = 1'b1;
    redirect_pc = 32'h102;
    tick(1);
    redirect = 1'b0;
    exp_q.delete();
    a0 = acc_cnt;
    @(negedge clk);
    chk("mis_pc_error", {31'b0, pc_error}, 1);
    chk("mis_req_valid", {31'b0, req_valid}, 0);
    chk("mis_req_addr", req_addr, 32'h102);
    repeat (6) @(negedge clk);
    chk("mis_no_accept", acc_cnt, a0);
    chk("mis_out_valid", {31'b0, out_valid}, 0);
    chk("mis_pc_error_hold", {31'b0, pc_error}, 1);
    tick(1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    @(negedge clk);
    chk("al_pc_error", {31'b0, pc_error}, 0);
    chk("al_req_valid", {31'b0, req_valid}, 1);
    chk("al_req_addr", req_addr, 32'h200);
    d0 = deliv;
    tick(10);
    chk("al_stream", 32'(deliv - d0 >= 5), 1);
    // Reset in the middle of operation with entries buffered.
    out_ready = 1'b0;
    n = 0;
    while (req_valid && n < 20) begin @(negedge clk); n++; end
    chk("mid_timeout", 32'(n < 20), 1);
    repeat (2) @(negedge clk);
    chk("mid_buffered", {31'b0, out_valid}, 1);
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_out_valid", {31'b0, out_valid}, 0);
    chk("mid_req_valid", {31'b0, req_valid}, 0);
    chk("mid_req_addr", req_addr, 0);
    chk("mid_out_pc", out_pc, 0);
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    chk("rel_req_valid", {31'b0, req_valid}, 1);
    chk("rel_req_addr", req_addr, 0);
    d0 = deliv;
    tick(10);
    chk("rel_stream", 32'(deliv - d0 >= 5), 1);
    // 8-bit PC: fetch at 0xFC overflows, raising the error after one request.
    tick(1);
    rst8 = 1'b0;
    redirect8 = 1'b1;
    redirect_pc8 = 8'hFC;
    @(negedge clk);
    chk("x8_redir_req_valid", {31'b0, req_valid8}, 0);
    chk("x8_redir_pc_error", {31'b0, pc_error8}, 0);
    tick(1);
    redirect8 = 1'b0;
    exp8.push_back(8'hFC);
    @(negedge clk);
    chk("x8_req_valid", {31'b0, req_valid8}, 1);
    chk("x8_req_addr", {24'b0, req_addr8}, 32'hFC);
    tick(1);
    @(negedge clk);
    chk("x8_pc_error", {31'b0, pc_error8}, 1);
    chk("x8_req_valid_off", {31'b0, req_valid8}, 0);
    chk("x8_wrap_addr", {24'b0, req_addr8}, 0);
    repeat (5) @(negedge clk);
    chk("x8_acc", acc8, 1);
    chk("x8_deliv", deliv8, 1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction fetch stage with a decoupled instruction-memory request/response interface, a DEPTH-entry in-order prefetch buffer and redirect-driven flushing. It sits between the instruction memory and decode, delivering (pc, instr) pairs over a valid/ready handshake. Next-PC selection (branch/jump target) is computed upstream and arrives as a single redirect. Overflow and misalignment raise a sticky error.

## Interface
- XLEN, 32, address/PC width (≥ 8)
- DEPTH, 4, prefetch buffer entries; power of 2, ≥ 2 (≥ 3 for one instr/cycle)
- RESET_VEC, 0, PC fetched first after reset; bits [1:0] must be 0
- fetch_clk  in  1  sole clock; all state on rising edge
- fetch_rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in-order, one per accepted request, no backpressure, ≥ 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart at redirect_pc (one-cycle pulse)
- redirect_pc  in  XLEN  new fetch PC
- out_valid  out  1  instruction available
- out_ready  in  1  decode accepts
- out_pc  out  XLEN  PC of out_instr
- out_instr  out  32  instruction word
- pc_error  out  1  sticky fetch error

## Operation
- State: fetch PC fpc, buffer entries {pc, instr, filled}, alloc/fill/head pointers, occupancy count occ (allocated entries), drop counter drop_cnt, err flag.
- Request: imem_req_valid = !fetch_rst && !err && !redirect_valid && (occ + drop_cnt < DEPTH); imem_req_addr = fpc.
- Request handshake: allocate entry at alloc pointer with pc = fpc, filled = 0; fpc <= fpc + 4.
- Response with drop_cnt = 0: write data into entry at fill pointer, filled = 1, advance fill pointer. With drop_cnt > 0: discard, drop_cnt − 1.
- Output: out_valid = head entry allocated and filled; out_pc/out_instr from head. Handshake frees head.
- Redirect: all entries invalidated, pointers and occ to 0; drop_cnt <= drop_cnt + (unfilled allocated entries) − (imem_rsp_valid this cycle); fpc <= redirect_pc. No request in the redirect cycle.
- Error: pc_error = err. err set when an accepted request has fpc + 4 overflow (carry out of XLEN; fpc wraps to 0) or when a redirect has redirect_pc[1:0] != 0 (fpc still loaded). While err, no new requests; outstanding responses and buffered entries still drain. err cleared only by reset or an aligned redirect.

## Timing
- Reset values: imem_req_valid 0 (while fetch_rst high), imem_req_addr RESET_VEC, out_valid 0, out_pc 0, out_instr 0, pc_error 0, occ 0, drop_cnt 0.
- First request: cycle after reset release, addr RESET_VEC.
- Latency: request accepted cycle N, response cycle N+1 → out_valid cycle N+2.
- Throughput: 1 instr/cycle sustained with 1-cycle memory and out_ready high when DEPTH ≥ 3.
- Full: occ + drop_cnt = DEPTH → imem_req_valid 0, fpc holds; out pop frees a slot, request the next cycle.
- Empty: out_valid 0, out_pc/out_instr don't-care.
- Simultaneous redirect + out handshake: instruction counts as delivered, then flush.
- Simultaneous redirect + response: response is stale and discarded.
- Redirect with imem_req_ready high: no request taken (valid low).
- Reset mid-operation: all state returns to reset values immediately; memory must also drop outstanding responses.
- out_pc/out_instr stable while out_valid && !out_ready.

## Structure
- Package fetch_pkg: ILEN = 32, default XLEN, fetch_entry_t struct {pc, instr, filled}, pointer-width helper ($clog2(DEPTH)).
- Sub-module fetch_buffer: circular DEPTH-entry store with alloc/fill/pop ports, occ count and flush.
- fpc + 4 with carry through the existing adder_rv; fpc register through en_ff (reset value RESET_VEC).

## Test plan
- Reset release, 1-cycle memory, out_ready high → requests 0x0, 0x4, 0x8…; out_valid from cycle 2, out_pc 0x0, 0x4, 0x8 every cycle.
- out_ready low, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid 0; raising out_ready delivers 0x0..0xC in order and fetching resumes at 0x10.
- 3 requests outstanding, redirect to 0x100 → 3 stale responses discarded, next out_pc 0x100, no 0x0-stream instruction delivered afterward.
- Redirect to 0x102 → pc_error 1, imem_req_valid 0; later redirect to 0x200 → pc_error 0, fetch at 0x200.
- XLEN=8, redirect to 0xFC → request 0xFC accepted, pc_error 1, no further requests; instruction at 0xFC still delivered.
- Assert fetch_rst while 2 entries buffered → out_valid 0 and imem_req_valid 0 immediately; after release, first request RESET_VEC.
